// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz from a 100 MHz clock) and coordinate helpers.
// The sync generator and the downstream text blocks all import this package.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int COUNT_W = 10;
    typedef logic [COUNT_W-1:0] coord_t;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the character/ROM-address path.
// master drives the timing, slave consumes it.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   frame_start;

    modport master (
        output p_tick,
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output frame_start
    );

    modport slave (
        input p_tick,
        input hsync,
        input vsync,
        input video_on,
        input pixel_x,
        input pixel_y,
        input frame_start
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel clock-enable: counts 0..CLK_DIV-1 and flags the last count as the tick.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = div_reg + 1'b1;
        if (div_reg == DIV_LAST) begin
            div_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end

    assign tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel tick, h/v counters, sync/visible decode and an aligned output register.
// All outputs change together on the clock that carries p_tick and hold for the rest of the pixel.
module vga_sync_gen #(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic           clk,
    input  logic           reset_n,
    vga_sync_gen_if.master vga
);

    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::SYNC_ACTIVE;
    import vga_timing_pkg::in_window;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // 10-bit counters cannot represent longer lines or frames.
    if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
        always_ff @(posedge clk) begin
            assert (1'b0) else $error("vga_sync_gen: illegal timing parameters");
        end
    end

    logic tick;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // The counters always hold the pixel that the next tick will present.
    coord_t h_count_reg, h_count_next;
    coord_t v_count_reg, v_count_next;

    always_comb begin
        h_count_next = h_count_reg;
        v_count_next = v_count_reg;
        if (tick) begin
            if (h_count_reg == H_LAST) begin
                h_count_next = '0;
                v_count_next = (v_count_reg == V_LAST) ? coord_t'(0) : v_count_reg + 1'b1;
            end else begin
                h_count_next = h_count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
        end
    end

    logic hsync_next;
    logic vsync_next;
    logic video_on_next;
    logic frame_origin;

    always_comb begin
        hsync_next    = in_window(h_count_reg, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next    = in_window(v_count_reg, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_next = (h_count_reg < H_VIS) && (v_count_reg < V_VIS);
        frame_origin  = (h_count_reg == '0) && (v_count_reg == '0);
    end

    logic   p_tick_reg;
    logic   frame_start_reg;
    logic   hsync_reg;
    logic   vsync_reg;
    logic   video_on_reg;
    coord_t pixel_x_reg;
    coord_t pixel_y_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_tick_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            hsync_reg       <= ~SYNC_ACTIVE;
            vsync_reg       <= ~SYNC_ACTIVE;
            video_on_reg    <= 1'b0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
        end else begin
            p_tick_reg      <= tick;
            frame_start_reg <= tick && frame_origin;
            if (tick) begin
                hsync_reg    <= hsync_next;
                vsync_reg    <= vsync_next;
                video_on_reg <= video_on_next;
                pixel_x_reg  <= h_count_reg;
                pixel_y_reg  <= v_count_reg;
            end
        end
    end

    assign vga.p_tick      = p_tick_reg;
    assign vga.frame_start = frame_start_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.video_on    = video_on_reg;
    assign vga.pixel_x     = pixel_x_reg;
    assign vga.pixel_y     = pixel_y_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken 23x13 raster (16x8 visible) with CLK_DIV=4.
module tb_vga_sync_gen;

    localparam int CLK_DIV = 4;
    localparam int HT = 23;              // 16 + 2 + 3 + 2
    localparam int VT = 13;              // 8 + 2 + 2 + 1
    localparam int FRAME_TICKS = HT * VT; // 299

    typedef struct {
        int   n;
        int   cyc;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic fs;
    } exp_t;

    logic clk;
    logic reset_n;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .CLK_DIV   (CLK_DIV),
        .H_DISPLAY (16),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (8),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_x = 0;
    int   last_y = 0;
    logic last_hs = 1'b1;
    logic last_vs = 1'b1;
    logic last_von = 1'b0;
    int   cnt_hs_line0 = 0;
    int   cnt_vs_frame = 0;
    int   cnt_von_frame = 0;
    int   cnt_fs = 0;

    function automatic void chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_p_tick"}, int'(vif.p_tick), 0);
        chk({tag, "_hsync"}, int'(vif.hsync), 1);
        chk({tag, "_vsync"}, int'(vif.vsync), 1);
        chk({tag, "_video_on"}, int'(vif.video_on), 0);
        chk({tag, "_pixel_x"}, int'(vif.pixel_x), 0);
        chk({tag, "_pixel_y"}, int'(vif.pixel_y), 0);
        chk({tag, "_frame_start"}, int'(vif.frame_start), 0);
    endtask

    // Sync window 18..20 horizontally, 10..11 vertically; visible x<16, y<8.
    task automatic push_ticks(input int count);
        for (int n = 0; n < count; n++) begin
            exp_t e;
            e.n   = n;
            e.cyc = CLK_DIV * (n + 1);
            e.x   = n % HT;
            e.y   = (n / HT) % VT;
            e.hs  = (e.x >= 18 && e.x <= 20) ? 1'b0 : 1'b1;
            e.vs  = (e.y >= 10 && e.y <= 11) ? 1'b0 : 1'b1;
            e.von = (e.x < 16) && (e.y < 8);
            e.fs  = (e.x == 0) && (e.y == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int waited = 0;
        while (exp_q.size() != 0 && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            cyc      = 0;
            last_x   = 0;
            last_y   = 0;
            last_hs  = 1'b1;
            last_vs  = 1'b1;
            last_von = 1'b0;
        end else begin
            cyc++;
            if (vif.p_tick) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] tick n=%0d cyc=%0d pixel=(%0d,%0d) hs=%0b vs=%0b von=%0b fs=%0b",
                             e.n, cyc, vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync,
                             vif.video_on, vif.frame_start);
                    chk($sformatf("tick_cycle@%0d", e.n), cyc, e.cyc);
                    chk($sformatf("pixel_x@%0d", e.n), int'(vif.pixel_x), e.x);
                    chk($sformatf("pixel_y@%0d", e.n), int'(vif.pixel_y), e.y);
                    chk($sformatf("hsync@%0d", e.n), int'(vif.hsync), int'(e.hs));
                    chk($sformatf("vsync@%0d", e.n), int'(vif.vsync), int'(e.vs));
                    chk($sformatf("video_on@%0d", e.n), int'(vif.video_on), int'(e.von));
                    chk($sformatf("frame_start@%0d", e.n), int'(vif.frame_start), int'(e.fs));
                    if (e.n < HT && !vif.hsync) cnt_hs_line0++;
                    if (e.n < FRAME_TICKS && !vif.vsync) cnt_vs_frame++;
                    if (e.n < FRAME_TICKS && vif.video_on) cnt_von_frame++;
                    if (vif.frame_start) cnt_fs++;
                    last_x   = e.x;
                    last_y   = e.y;
                    last_hs  = e.hs;
                    last_vs  = e.vs;
                    last_von = e.von;
                end
            end else begin
                chk("hold_pixel_x", int'(vif.pixel_x), last_x);
                chk("hold_pixel_y", int'(vif.pixel_y), last_y);
                chk("hold_hsync", int'(vif.hsync), int'(last_hs));
                chk("hold_vsync", int'(vif.vsync), int'(last_vs));
                chk("hold_video_on", int'(vif.video_on), int'(last_von));
                chk("idle_frame_start", int'(vif.frame_start), 0);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_reset("reset_hold");

        // One full frame plus the next frame up to pixel (10,5).
        push_ticks(FRAME_TICKS + 5 * HT + 11);
        reset_n = 1'b1;
        drain((FRAME_TICKS + 5 * HT + 11) * CLK_DIV + 20);

        chk("pre_abort_pixel_x", int'(vif.pixel_x), 10);
        chk("pre_abort_pixel_y", int'(vif.pixel_y), 5);
        chk("hsync_low_ticks_line", cnt_hs_line0, 3);
        chk("vsync_low_ticks_frame", cnt_vs_frame, 46);
        chk("video_on_ticks_frame", cnt_von_frame, 128);
        chk("frame_start_count", cnt_fs, 2);

        // Abort in the middle of a clock low phase; outputs must clear before the next edge.
        #1 reset_n = 1'b0;
        #1;
        check_reset("async_abort");
        repeat (5) @(negedge clk);
        #1;
        check_reset("abort_hold");

        push_ticks(30);
        reset_n = 1'b1;
        drain(30 * CLK_DIV + 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
